r_adder: RTL and testbench
==========================

# r_adder

Registered ripple-carry adder. It adds two unsigned WIDTH-bit operands through an explicit chain of 1-bit full-adder cells and registers the sum and carry-out. A valid flag travels alongside the data. It is a leaf arithmetic block for counter and datapath logic, with no backpressure.

## Interface
Parameters:
- WIDTH, default 4: operand and sum width; legal range 1 to 32.

Ports:
- clk, input, 1: rising-edge clock; the only clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1: A and B are valid this cycle.
- A, input, WIDTH: operand A, unsigned.
- B, input, WIDTH: operand B, unsigned.
- S, output, WIDTH: registered sum, A+B modulo 2^WIDTH.
- Cout, output, 1: registered carry-out of the MSB cell.
- out_valid, output, 1: S and Cout hold a new result.
- Ovf, output, 1: registered signed-overflow flag. Present only when R_ADDER_OVF_EN is defined.

## Operation
- The combinational core is WIDTH full-adder cells in series.
  - Cell i computes s[i] = A[i]^B[i]^c[i] and c[i+1] = A[i]&B[i] | c[i]&(A[i]^B[i]).
  - c[0] is 0. Cout is c[WIDTH].
- The carry chain is built as an explicit ripple structure. It must not be inferred as a single "+" operator.
- The full-adder cell is a separate submodule instantiated WIDTH times in a generate loop.
- {Cout,S} equals the (WIDTH+1)-bit unsigned sum of A and B, with no truncation of the carry.
- On each rising clk edge with in_valid=1:
  - S is loaded with s[WIDTH-1:0].
  - Cout is loaded with c[WIDTH].
  - Ovf is loaded with c[WIDTH]^c[WIDTH-1]. For WIDTH=1 this is c[1]^c[0].
- On each rising edge with in_valid=0, S, Cout and Ovf hold their values.
- out_valid is loaded with in_valid on every rising edge.
- A and B are don't-care when in_valid=0. X on A or B while in_valid=0 must not propagate into the registers.
- There is no internal state beyond the output registers and the valid register.

## Timing
- Latency is 1 cycle. Operands sampled at edge N appear on S/Cout/Ovf and out_valid=1 after edge N.
- Throughput is 1 result per cycle. Back-to-back in_valid produces back-to-back out_valid.
- Reset:
  - While rst_n=0, S=0, Cout=0, Ovf=0 and out_valid=0, asynchronously and without waiting for clk.
  - Reset deasserted on the same edge that samples in_valid=1: that edge is ignored. Capture starts on the first rising edge with rst_n=1.
  - Reset asserted mid-stream: any pending result is discarded. out_valid drops immediately.
- Wrap-around: all-ones plus all-ones gives S = all-ones minus 1 (LSB 0), Cout=1.
- Sum exactly 2^WIDTH gives S=0, Cout=1.
- The critical path is the WIDTH-cell carry chain, which must fit in one clk period. No internal pipelining.

## Configuration
- R_ADDER_OVF_EN defined:
  - The Ovf port and its register exist.
  - Ovf=1 when A and B, read as two's-complement numbers, have the same sign and the sum's MSB differs from that sign.
- R_ADDER_OVF_EN undefined:
  - No Ovf port, no overflow logic.
  - S, Cout and out_valid behave identically to the enabled build.

## Test plan
All scenarios use WIDTH=4 and one in_valid pulse each. Check one cycle later.
- Reset: hold rst_n=0 with in_valid toggling -> S=0000, Cout=0, Ovf=0, out_valid=0 throughout. Drop rst_n asynchronously mid-cycle after a result -> outputs clear before the next edge.
- Basic sums:
  - A=0000, B=0000 -> S=0000, Cout=0, Ovf=0.
  - A=0001, B=0001 -> S=0010, Cout=0, Ovf=0.
- Carry out of the MSB:
  - A=1010, B=0110 -> S=0000, Cout=1, Ovf=0.
  - A=1101, B=0101 -> S=0010, Cout=1, Ovf=0.
  - A=1111, B=1111 -> S=1110, Cout=1, Ovf=0.
- Signed overflow, OVF build:
  - A=0111, B=0001 -> S=1000, Cout=0, Ovf=1.
  - A=1000, B=1000 -> S=0000, Cout=1, Ovf=1.
- Hold and streaming:
  - Apply the five basic and carry vectors back-to-back, then in_valid=0 with A=1111, B=0001.
  - Required: five consecutive out_valid=1 cycles with matching results, then out_valid=0 with S=1110, Cout=1 held.
- Exhaustive random: all 256 (A,B) pairs with random in_valid gaps -> {Cout,S} == A+B on each out_valid. Ovf matches the signed rule in the enabled build.

Source files
------------

// File: rtl/r_adder.sv
// r_adder: registered ripple-carry adder.
//
// Adds two unsigned WIDTH-bit operands through a chain of WIDTH 1-bit
// full-adder cells. The sum, carry-out and a valid flag are registered.
// There is no backpressure.
//
// Valid semantics: on a rising clk edge with in_valid=1, A and B are consumed.
// The result appears on S/Cout (and Ovf) with out_valid=1 after that same edge.
// On an edge with in_valid=0, the result registers hold and out_valid=0.
// out_valid follows in_valid with one cycle of delay on every edge.
//
// Optional feature: define R_ADDER_OVF_EN to add the registered signed-overflow
// output Ovf.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   A/B valid this cycle
//   A, B      in   WIDTH-bit unsigned operands
//   S         out  registered sum, A+B mod 2^WIDTH
//   Cout      out  registered carry-out of the MSB cell
//   Ovf       out  registered signed overflow (only with R_ADDER_OVF_EN)
//   out_valid out  S/Cout/Ovf hold a new result

module r_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module r_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
`ifdef R_ADDER_OVF_EN
  output logic             Ovf,
`endif
  output logic             out_valid
);

  // c[i] is the carry into cell i; c[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    r_adder_fa u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  // The result registers load only when in_valid is high. Operand values,
  // including X, on an idle cycle never reach the registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S         <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S    <= sum;
        Cout <= c[WIDTH];
      end
    end
  end

`ifdef R_ADDER_OVF_EN
  // Signed overflow means the carry into the sign cell differs from the carry
  // out of it. For WIDTH=1 this compares c[1] with c[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Ovf <= 1'b0;
    end else if (in_valid) begin
      Ovf <= c[WIDTH] ^ c[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_r_adder.sv
// Testbench for r_adder at WIDTH=4.
//
// The driver pushes the expected {ovf,cout,s} into exp_q when an operand pair
// is accepted. The monitor runs on the falling edge. It pops and compares an
// entry whenever out_valid is high. On idle cycles it checks that the last
// result is still held. During reset it checks that all outputs are zero.

module tb_r_adder;
  localparam int W = 4;
`ifdef R_ADDER_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] S;
  logic         Cout;
  logic         out_valid;
  logic         ovf_act;

  logic [W+1:0] exp_q[$];
  logic [W+1:0] last_exp;
  int           n_checks;
  int           n_fail;

  r_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .S         (S),
    .Cout      (Cout),
`ifdef R_ADDER_OVF_EN
    .Ovf       (ovf_act),
`endif
    .out_valid (out_valid)
  );

`ifndef R_ADDER_OVF_EN
  assign ovf_act = 1'b0;
`endif

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the result is computed with integer arithmetic,
  // and signed overflow is found by the signed range test.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int          usum;
    int          sa;
    int          sb;
    int          ssum;
    logic        ovf;
    logic [W:0]  wide;
    usum = int'(a) + int'(b);
    sa   = (int'(a) >= (1 << (W-1))) ? int'(a) - (1 << W) : int'(a);
    sb   = (int'(b) >= (1 << (W-1))) ? int'(b) - (1 << W) : int'(b);
    ssum = sa + sb;
    ovf  = OVF_ON && ((ssum > (1 << (W-1)) - 1) || (ssum < -(1 << (W-1))));
    wide = usum[W:0];
    return {ovf, wide};
  endfunction

  task automatic check(input string name, input logic [W+2:0] act, input logic [W+2:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
    end
  endtask

  // Driver: apply inputs just after an edge, then let the next edge sample them.
  task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = v;
    A        = a;
    B        = b;
    @(posedge clk);
    if (v && rst_n) exp_q.push_back(model(a, b));
    #1;
  endtask

  task automatic idle_rand();
    cycle(1'b0, W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)));
  endtask

  // Monitor and scoreboard.
  always @(negedge clk) begin
    logic [W+1:0] act;
    logic [W+1:0] e;
    act = {ovf_act, Cout, S};
    if (!rst_n) begin
      exp_q.delete();
      last_exp = '0;
      check("reset_outputs", {out_valid, act}, '0);
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {1'b1, act}, {1'b0, act});
      end else begin
        e = exp_q.pop_front();
        check("result", {1'b1, act}, {1'b1, e});
        last_exp = e;
      end
    end else begin
      check("hold", {1'b0, act}, {1'b0, last_exp});
    end
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // Directed vectors: basic sums, carries, and signed-overflow cases.
  logic [W-1:0] va[7];
  logic [W-1:0] vb[7];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    last_exp = '0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;
    va = '{4'b0000, 4'b0001, 4'b1010, 4'b1101, 4'b1111, 4'b0111, 4'b1000};
    vb = '{4'b0000, 4'b0001, 4'b0110, 4'b0101, 4'b1111, 4'b0001, 4'b1000};

    // Hold reset while in_valid toggles. The monitor checks the outputs are zero.
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++)
      cycle(1'(i % 2), W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
    rst_n = 1'b1;
    cycle(1'b0, '0, '0);

    // Apply the five basic and carry vectors back to back, then an idle cycle
    // with A=1111, B=0001 that must not disturb the held S=1110, Cout=1.
    for (int i = 0; i < 5; i++) cycle(1'b1, va[i], vb[i]);
    cycle(1'b0, 4'b1111, 4'b0001);
    cycle(1'b0, 4'b1111, 4'b0001);

    // Signed-overflow vectors, each sent as a single pulse.
    for (int i = 5; i < 7; i++) begin
      cycle(1'b1, va[i], vb[i]);
      cycle(1'b0, '0, '0);
    end

    // Assert reset asynchronously mid-cycle while a result is shown.
    cycle(1'b1, 4'b1111, 4'b1111);
    cycle(1'b0, '0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", {out_valid, Cout, S}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(1'b0, '0, '0);

    // Assert reset just after an edge that captured a result. The pending
    // result is dropped and out_valid falls at once.
    cycle(1'b1, 4'b0110, 4'b0111);
    rst_n = 1'b0;
    #1;
    check("reset_discard", {out_valid, Cout, S}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(1'b0, '0, '0);

    // Exhaustive sweep of all operand pairs, with random idle gaps.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        cycle(1'b1, W'(a), W'(b));
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle_rand();
      end
    end

    // Drain the pipeline, then confirm every expected result was seen.
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
